// File: rtl/bit_reversal_sequencer_pkg.sv
// Shared types for the bit-reversal sequencer: step code width, coefficient and
// polynomial types, and the controller state encoding.
package ntt_ctrl_pkg;

  localparam int STEP_W    = 3;
  localparam int POLY_SIZE = 256;
  localparam int COEFF_W   = 32;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef coeff_t [POLY_SIZE-1:0] poly_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OUT
  } seq_state_t;

endpackage

// File: rtl/bit_reversal_sequencer_if.sv
// Start/result handshake bundle between a producer/consumer (master) and the
// sequencer (slave).
interface bit_reversal_sequencer_if
  import ntt_ctrl_pkg::*;
#(
  parameter int SIZE  = POLY_SIZE,
  parameter int WIDTH = COEFF_W
) ();

  logic                         start_valid;
  logic                         start_ready;
  logic [SIZE-1:0][WIDTH-1:0]   poly_in;
  logic                         bypass;
  logic [SIZE-1:0][WIDTH-1:0]   result;
  logic                         result_valid;
  logic                         result_ready;

  modport master (
    output start_valid, poly_in, bypass, result_ready,
    input  start_ready, result, result_valid
  );

  modport slave (
    input  start_valid, poly_in, bypass, result_ready,
    output start_ready, result, result_valid
  );

endinterface

// File: rtl/bit_reversal_sequencer_step_timer.sv
// Step and settle counters: holds each step code for SETTLE cycles, flags the
// capture cycle and the final capture.
module step_timer
  import ntt_ctrl_pkg::*;
#(
  parameter int FIRST_STEP = 1,
  parameter int LAST_STEP  = 7,
  parameter int SETTLE     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              advance,
  output logic [STEP_W-1:0] step_cnt,
  output logic              capture,
  output logic              last
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] settle_cnt;

  assign capture = (settle_cnt == '0);
  assign last    = capture && (step_cnt == STEP_W'(LAST_STEP));

  // The last step is never incremented past, so step_cnt cannot wrap at 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt   <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      step_cnt   <= '0;
      settle_cnt <= '0;
    end else if (load) begin
      step_cnt   <= STEP_W'(FIRST_STEP);
      settle_cnt <= SETTLE_INIT;
    end else if (advance) begin
      if (!capture) begin
        settle_cnt <= settle_cnt - 1'b1;
      end else if (!last) begin
        step_cnt   <= step_cnt + 1'b1;
        settle_cnt <= SETTLE_INIT;
      end
    end
  end

endmodule

// File: rtl/bit_reversal_sequencer.sv
// Sequencer that steps an external bit-reversal network over one working
// polynomial register and hands the result out by valid/ready.
module bit_reversal_sequencer
  import ntt_ctrl_pkg::*;
#(
  parameter int SIZE       = POLY_SIZE,
  parameter int WIDTH      = COEFF_W,
  parameter int FIRST_STEP = 1,
  parameter int LAST_STEP  = 7,
  parameter int SETTLE     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  bit_reversal_sequencer_if.slave    io,
  output logic [STEP_W-1:0]          net_step,
  output logic [SIZE-1:0][WIDTH-1:0] net_in,
  input  logic [SIZE-1:0][WIDTH-1:0] net_out,
  output logic                       busy
);

  if (FIRST_STEP > LAST_STEP) begin : g_bad_first
    $error("FIRST_STEP must not exceed LAST_STEP");
  end
  if (LAST_STEP > 7) begin : g_bad_last
    $error("LAST_STEP must be at most 7");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end
  if (SIZE != 256) begin : g_bad_size
    $error("SIZE must be 256");
  end

  seq_state_t                 state, state_next;
  logic [SIZE-1:0][WIDTH-1:0] work_reg;
  logic [STEP_W-1:0]          step_cnt;
  logic                       accept, load, capture, last;

  assign accept = (state == IDLE) && io.start_valid && !flush;

  step_timer #(
    .FIRST_STEP (FIRST_STEP),
    .LAST_STEP  (LAST_STEP),
    .SETTLE     (SETTLE)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .clear    (flush),
    .advance  (state == RUN),
    .step_cnt (step_cnt),
    .capture  (capture),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // flush overrides every other transition, including a pending handoff.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (io.bypass) begin
          state_next = OUT;
        end else begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN:  if (last) state_next = OUT;
      OUT:  if (io.result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg <= '0;
    end else if (accept) begin
      work_reg <= io.poly_in;
    end else if ((state == RUN) && capture && !flush) begin
      work_reg <= net_out;
    end
  end

  assign io.start_ready  = (state == IDLE);
  assign io.result_valid = (state == OUT);
  assign io.result       = work_reg;
  assign busy            = (state != IDLE);
  assign net_in          = work_reg;
  assign net_step        = (state == RUN) ? step_cnt : '0;

endmodule

// File: tb/tb_bit_reversal_sequencer.sv
// Directed bench: three sequencer configurations, each wired to a behavioural
// bit-reversal network (step s reverses the low s+1 index bits).
module tb_bit_reversal_sequencer;
  import ntt_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush_a = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  poly_t ramp, golden, partial, alt, expB;

  logic [STEP_W-1:0] net_step_a, net_step_b, net_step_c;
  poly_t net_in_a, net_in_b, net_in_c;
  poly_t net_out_a, net_out_b, net_out_c;
  logic busy_a, busy_b, busy_c;

  bit_reversal_sequencer_if #(.SIZE(256), .WIDTH(32)) io_a ();
  bit_reversal_sequencer_if #(.SIZE(256), .WIDTH(32)) io_b ();
  bit_reversal_sequencer_if #(.SIZE(256), .WIDTH(32)) io_c ();

  always #5 clk = ~clk;

  function automatic poly_t net_model(input poly_t din, input logic [2:0] step);
    poly_t dout;
    int k;
    logic [7:0] idx, src;
    k = int'(step) + 1;
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      src = idx;
      for (int b = 0; b < k; b++) src[b] = idx[k-1-b];
      dout[i] = din[src];
    end
    return dout;
  endfunction

  assign net_out_a = net_model(net_in_a, net_step_a);
  assign net_out_b = net_model(net_in_b, net_step_b);
  assign net_out_c = net_model(net_in_c, net_step_c);

  bit_reversal_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a), .io(io_a),
    .net_step(net_step_a), .net_in(net_in_a), .net_out(net_out_a), .busy(busy_a)
  );

  bit_reversal_sequencer #(.FIRST_STEP(1), .LAST_STEP(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .io(io_b),
    .net_step(net_step_b), .net_in(net_in_b), .net_out(net_out_b), .busy(busy_b)
  );

  bit_reversal_sequencer #(.SETTLE(3)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .io(io_c),
    .net_step(net_step_c), .net_in(net_in_c), .net_out(net_out_c), .busy(busy_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start request to the selected instance across a single edge.
  task automatic applyStimulus(input int which, input logic byp);
    case (which)
      0: begin io_a.bypass = byp; io_a.start_valid = 1'b1; end
      1: begin io_b.bypass = byp; io_b.start_valid = 1'b1; end
      default: begin io_c.bypass = byp; io_c.start_valid = 1'b1; end
    endcase
    tick();
    io_a.start_valid = 1'b0;
    io_b.start_valid = 1'b0;
    io_c.start_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic stable;
    logic sawValid;

    for (int i = 0; i < 256; i++) begin
      ramp[i] = 32'(i);
      alt[i]  = 32'hA500_0000 | 32'(i);
      expB[i] = 32'(i);
      if (i % 4 == 1) expB[i] = 32'(i + 1);
      if (i % 4 == 2) expB[i] = 32'(i - 1);
    end
    golden = ramp;
    for (int s = 1; s <= 7; s++) golden = net_model(golden, 3'(s));
    partial = ramp;
    for (int s = 1; s <= 3; s++) partial = net_model(partial, 3'(s));

    io_a.start_valid = 1'b0; io_a.bypass = 1'b0; io_a.result_ready = 1'b0; io_a.poly_in = ramp;
    io_b.start_valid = 1'b0; io_b.bypass = 1'b0; io_b.result_ready = 1'b0; io_b.poly_in = ramp;
    io_c.start_valid = 1'b0; io_c.bypass = 1'b0; io_c.result_ready = 1'b0; io_c.poly_in = ramp;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_start_ready", 32'(io_a.start_ready), 32'd1);
    checkOutput("rst_result_valid", 32'(io_a.result_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_net_step", 32'(net_step_a), 32'd0);
    checkOutput("rst_result_zero", 32'(io_a.result == '0), 32'd1);
    #9 rst_n = 1'b1;
    tick();

    // Default configuration: steps 1..7, one cycle each.
    applyStimulus(0, 1'b0);
    for (int s = 1; s <= 7; s++) begin
      checkOutput($sformatf("t1_step%0d", s), 32'(net_step_a), 32'(s));
      if (s == 7) checkOutput("t1_valid_early", 32'(io_a.result_valid), 32'd0);
      tick();
    end
    checkOutput("t1_valid", 32'(io_a.result_valid), 32'd1);
    checkOutput("t1_start_ready", 32'(io_a.start_ready), 32'd0);
    checkOutput("t1_net_step_out", 32'(net_step_a), 32'd0);
    checkOutput("t1_r1", io_a.result[1], 32'd128);
    checkOutput("t1_r2", io_a.result[2], 32'd32);
    checkOutput("t1_r128", io_a.result[128], 32'd64);
    checkOutput("t1_r255", io_a.result[255], 32'd255);
    checkOutput("t1_full", 32'(io_a.result == golden), 32'd1);
    io_a.result_ready = 1'b1;
    tick();
    io_a.result_ready = 1'b0;
    checkOutput("t1_drain_valid", 32'(io_a.result_valid), 32'd0);
    checkOutput("t1_drain_busy", 32'(busy_a), 32'd0);

    // Single-stage configuration swaps index bits 0 and 1.
    applyStimulus(1, 1'b0);
    checkOutput("t2_step", 32'(net_step_b), 32'd1);
    checkOutput("t2_valid_early", 32'(io_b.result_valid), 32'd0);
    tick();
    checkOutput("t2_valid", 32'(io_b.result_valid), 32'd1);
    checkOutput("t2_r0", io_b.result[0], 32'd0);
    checkOutput("t2_r1", io_b.result[1], 32'd2);
    checkOutput("t2_r2", io_b.result[2], 32'd1);
    checkOutput("t2_r3", io_b.result[3], 32'd3);
    checkOutput("t2_r5", io_b.result[5], 32'd6);
    checkOutput("t2_full", 32'(io_b.result == expB), 32'd1);
    io_b.result_ready = 1'b1;
    tick();
    io_b.result_ready = 1'b0;

    // Bypass goes straight to OUT with the input untouched.
    applyStimulus(0, 1'b1);
    io_a.bypass = 1'b0;
    checkOutput("t3_valid", 32'(io_a.result_valid), 32'd1);
    checkOutput("t3_net_step", 32'(net_step_a), 32'd0);
    checkOutput("t3_full", 32'(io_a.result == ramp), 32'd1);
    io_a.result_ready = 1'b1;
    tick();
    io_a.result_ready = 1'b0;

    // SETTLE=3 holds each step for three cycles; a start during RUN is dropped.
    applyStimulus(2, 1'b0);
    for (int s = 1; s <= 7; s++) begin
      for (int h = 0; h < 3; h++) begin
        checkOutput($sformatf("t4_step%0d_h%0d", s, h), 32'(net_step_c), 32'(s));
        if (s == 2 && h == 1) begin
          io_c.poly_in = alt;
          io_c.start_valid = 1'b1;
          checkOutput("t4_start_ready_busy", 32'(io_c.start_ready), 32'd0);
        end else begin
          io_c.start_valid = 1'b0;
        end
        if (s == 7 && h == 2) checkOutput("t4_valid_early", 32'(io_c.result_valid), 32'd0);
        tick();
      end
    end
    checkOutput("t4_valid", 32'(io_c.result_valid), 32'd1);
    checkOutput("t4_full", 32'(io_c.result == golden), 32'd1);

    // Back-pressure in OUT, then handoff with a simultaneous start.
    stable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (!(io_c.result_valid === 1'b1 && io_c.result == golden)) stable = 1'b0;
    end
    checkOutput("t5_stable", 32'(stable), 32'd1);
    io_c.result_ready = 1'b1;
    io_c.start_valid = 1'b1;
    io_c.bypass = 1'b1;
    tick();
    io_c.result_ready = 1'b0;
    checkOutput("t5_handoff_valid", 32'(io_c.result_valid), 32'd0);
    checkOutput("t5_handoff_ready", 32'(io_c.start_ready), 32'd1);
    tick();
    io_c.start_valid = 1'b0;
    io_c.bypass = 1'b0;
    checkOutput("t5_restart_valid", 32'(io_c.result_valid), 32'd1);
    checkOutput("t5_restart_full", 32'(io_c.result == alt), 32'd1);
    io_c.result_ready = 1'b1;
    tick();
    io_c.result_ready = 1'b0;

    // Flush at step 4 keeps the work register from the first three steps.
    applyStimulus(0, 1'b0);
    tick(); tick(); tick();
    checkOutput("t6_at_step4", 32'(net_step_a), 32'd4);
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    checkOutput("t6_flush_busy", 32'(busy_a), 32'd0);
    checkOutput("t6_flush_step", 32'(net_step_a), 32'd0);
    checkOutput("t6_flush_partial", 32'(io_a.result == partial), 32'd1);
    sawValid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (io_a.result_valid !== 1'b0) sawValid = 1'b1;
      tick();
    end
    checkOutput("t6_no_valid", 32'(sawValid), 32'd0);

    // Asynchronous reset mid-RUN returns outputs immediately.
    applyStimulus(0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", 32'(busy_a), 32'd0);
    checkOutput("t6_rst_step", 32'(net_step_a), 32'd0);
    checkOutput("t6_rst_ready", 32'(io_a.start_ready), 32'd1);
    checkOutput("t6_rst_result", 32'(io_a.result == '0), 32'd1);
    #1 rst_n = 1'b1;
    tick();

    applyStimulus(0, 1'b0);
    for (int n = 0; n < 6; n++) tick();
    checkOutput("t6_rerun_early", 32'(io_a.result_valid), 32'd0);
    tick();
    checkOutput("t6_rerun_valid", 32'(io_a.result_valid), 32'd1);
    checkOutput("t6_rerun_full", 32'(io_a.result == golden), 32'd1);
    io_a.result_ready = 1'b1;
    tick();
    io_a.result_ready = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
